// File: rtl/lvt_write_arbiter.sv
// Round-robin arbiter sharing the PORTS write ports of an LVT memory among REQS requesters.
// Zero-fills the memory after reset. Define LVT_WRITE_ARBITER_STATS_EN to add grant/conflict counters.
module lvt_write_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512,
    parameter int PORTS = 2,
    parameter int REQS  = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [REQS-1:0]             req_valid,
    input  logic [REQS-1:0][AW-1:0]     req_addr,
    input  logic [REQS-1:0][WIDTH-1:0]  req_data,
    output logic [REQS-1:0]             req_ready,
    output logic [PORTS-1:0][AW-1:0]    mem_addr,
    output logic [PORTS-1:0]            mem_en,
    output logic [PORTS-1:0][WIDTH-1:0] mem_d,
    output logic                        init_done
`ifdef LVT_WRITE_ARBITER_STATS_EN
    ,
    output logic [31:0]                 grant_cnt,
    output logic [31:0]                 conflict_cnt
`endif
);

    localparam int SWEEP = (DEPTH + PORTS - 1) / PORTS;
    localparam int CW    = $clog2(SWEEP + 1);
    localparam int PW    = $clog2(REQS);

    typedef enum logic {INIT, RUN} state_t;

    state_t                      state, state_nxt;
    logic [CW-1:0]               cnt;
    logic [PW-1:0]               ptr, ptr_nxt;
    logic [REQS-1:0]             grant;
    logic                        conflict;
    logic [PORTS-1:0]            en_nxt;
    logic [PORTS-1:0][AW-1:0]    addr_nxt;
    logic [PORTS-1:0][WIDTH-1:0] d_nxt;

    // State register, sweep counter and rr pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            ptr       <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            init_done <= (state == RUN);
            if (state == INIT)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && cnt == CW'(SWEEP - 1))
            state_nxt = RUN;
    end

    // Grant scan: granted addresses are kept in addr_nxt so later requesters compare against them
    always_comb begin
        int  k;
        int  a;
        logic hit;
        grant    = '0;
        conflict = 1'b0;
        ptr_nxt  = ptr;
        en_nxt   = '0;
        addr_nxt = '0;
        d_nxt    = '0;
        k        = 0;
        a        = 0;
        hit      = 1'b0;
        if (state == RUN) begin
            for (int i = 0; i < REQS; i++) begin
                for (int r = 0; r < REQS; r++) begin
                    if (r == (int'(ptr) + i) % REQS && req_valid[r] && k < PORTS) begin
                        hit = 1'b0;
                        for (int j = 0; j < PORTS; j++)
                            if (j < k && addr_nxt[j] == req_addr[r])
                                hit = 1'b1;
                        if (hit) begin
                            conflict = 1'b1;
                        end else begin
                            grant[r] = 1'b1;
                            for (int p = 0; p < PORTS; p++) begin
                                if (p == k) begin
                                    en_nxt[p]   = 1'b1;
                                    addr_nxt[p] = req_addr[r];
                                    d_nxt[p]    = req_data[r];
                                end
                            end
                            ptr_nxt = PW'((r + 1) % REQS);
                            k       = k + 1;
                        end
                    end
                end
            end
        end else begin
            for (int p = 0; p < PORTS; p++) begin
                a           = int'(cnt) * PORTS + p;
                en_nxt[p]   = (a < DEPTH);
                addr_nxt[p] = AW'(a);
            end
        end
    end

    always_comb begin
        req_ready = grant;
    end

    // Registered memory write stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en   <= '0;
            mem_addr <= '0;
            mem_d    <= '0;
        end else begin
            mem_en   <= en_nxt;
            mem_addr <= addr_nxt;
            mem_d    <= d_nxt;
        end
    end

`ifdef LVT_WRITE_ARBITER_STATS_EN
    function automatic logic [31:0] sat_add(input logic [31:0] base, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, base} + {1'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    logic [31:0] grant_num;
    always_comb begin
        grant_num = '0;
        for (int r = 0; r < REQS; r++)
            grant_num = grant_num + {31'd0, grant[r]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt    <= '0;
            conflict_cnt <= '0;
        end else begin
            grant_cnt    <= sat_add(grant_cnt, grant_num);
            conflict_cnt <= sat_add(conflict_cnt, {31'd0, conflict});
        end
    end
`endif

endmodule

// File: tb/tb_lvt_write_arbiter.sv
// Directed table-driven bench for lvt_write_arbiter (REQS=4, PORTS=2, DEPTH=8, WIDTH=8).
// Optional counters are checked when LVT_WRITE_ARBITER_STATS_EN is defined.
module tb_lvt_write_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int PORTS = 2;
    localparam int REQS  = 4;
    localparam int AW    = 3;

    logic                        clk;
    logic                        rst;
    logic [REQS-1:0]             req_valid;
    logic [REQS-1:0][AW-1:0]     req_addr;
    logic [REQS-1:0][WIDTH-1:0]  req_data;
    logic [REQS-1:0]             req_ready;
    logic [PORTS-1:0][AW-1:0]    mem_addr;
    logic [PORTS-1:0]            mem_en;
    logic [PORTS-1:0][WIDTH-1:0] mem_d;
    logic                        init_done;
`ifdef LVT_WRITE_ARBITER_STATS_EN
    logic [31:0]                 grant_cnt;
    logic [31:0]                 conflict_cnt;
`endif

    lvt_write_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .REQS(REQS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_d(mem_d), .init_done(init_done)
`ifdef LVT_WRITE_ARBITER_STATS_EN
        , .grant_cnt(grant_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]      valid;
        logic [3:0][2:0] addr;
        logic [3:0][7:0] data;
        logic [3:0]      ready;
        logic [1:0]      en;
        logic [2:0]      a0;
        logic [2:0]      a1;
        logic [7:0]      d0;
        logic [7:0]      d1;
    } vec_t;

    vec_t tv[13];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // valid, addr{r3,r2,r1,r0}, data{r3,r2,r1,r0}, ready, en, a0, a1, d0, d1
        tv[0]  = '{4'b1111, {3'd4,3'd3,3'd2,3'd1}, {8'h44,8'h33,8'h22,8'h11}, 4'b0011, 2'b11, 3'd1, 3'd2, 8'h11, 8'h22};
        tv[1]  = '{4'b1100, {3'd4,3'd3,3'd2,3'd1}, {8'h44,8'h33,8'h22,8'h11}, 4'b1100, 2'b11, 3'd3, 3'd4, 8'h33, 8'h44};
        tv[2]  = '{4'b0111, {3'd0,3'd5,3'd3,3'd3}, {8'h00,8'h5C,8'h3B,8'h3A}, 4'b0101, 2'b11, 3'd3, 3'd5, 8'h3A, 8'h5C};
        tv[3]  = '{4'b0010, {3'd0,3'd5,3'd3,3'd3}, {8'h00,8'h5C,8'h3B,8'h3A}, 4'b0010, 2'b01, 3'd3, 3'd0, 8'h3B, 8'h00};
        tv[4]  = '{4'b1000, {3'd7,3'd0,3'd0,3'd0}, {8'hA5,8'h00,8'h00,8'h00}, 4'b1000, 2'b01, 3'd7, 3'd0, 8'hA5, 8'h00};
        tv[5]  = '{4'b1111, {3'd6,3'd6,3'd6,3'd6}, {8'h04,8'h03,8'h02,8'h01}, 4'b0001, 2'b01, 3'd6, 3'd0, 8'h01, 8'h00};
        tv[6]  = '{4'b1110, {3'd6,3'd6,3'd6,3'd6}, {8'h04,8'h03,8'h02,8'h01}, 4'b0010, 2'b01, 3'd6, 3'd0, 8'h02, 8'h00};
        tv[7]  = '{4'b1100, {3'd6,3'd6,3'd6,3'd6}, {8'h04,8'h03,8'h02,8'h01}, 4'b0100, 2'b01, 3'd6, 3'd0, 8'h03, 8'h00};
        tv[8]  = '{4'b1000, {3'd6,3'd6,3'd6,3'd6}, {8'h04,8'h03,8'h02,8'h01}, 4'b1000, 2'b01, 3'd6, 3'd0, 8'h04, 8'h00};
        tv[9]  = '{4'b0000, {3'd6,3'd6,3'd6,3'd6}, {8'h04,8'h03,8'h02,8'h01}, 4'b0000, 2'b00, 3'd0, 3'd0, 8'h00, 8'h00};
        tv[10] = '{4'b1111, {3'd3,3'd2,3'd1,3'd0}, {8'hD3,8'hD2,8'hD1,8'hD0}, 4'b0011, 2'b11, 3'd0, 3'd1, 8'hD0, 8'hD1};
        tv[11] = '{4'b1100, {3'd3,3'd2,3'd1,3'd0}, {8'hD3,8'hD2,8'hD1,8'hD0}, 4'b1100, 2'b11, 3'd2, 3'd3, 8'hD2, 8'hD3};
        tv[12] = '{4'b1010, {3'd5,3'd0,3'd2,3'd0}, {8'hE3,8'h00,8'hE1,8'h00}, 4'b1010, 2'b11, 3'd2, 3'd5, 8'hE1, 8'hE3};

        rst       = 1'b1;
        req_valid = 4'b1111;
        req_addr  = '0;
        req_data  = '0;
        #12;
        chk("reset mem_en", 32'(mem_en), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // INIT sweep: four cycles covering addresses 0..7
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("init req_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            chk("init mem_en", 32'(mem_en), 32'd3);
            chk("init addr0", 32'(mem_addr[0]), 32'(2 * c));
            chk("init addr1", 32'(mem_addr[1]), 32'(2 * c + 1));
            chk("init mem_d", 32'(mem_d), 32'd0);
            chk("init init_done", 32'(init_done), 32'd0);
            if (c == 3) req_valid = 4'b0000;
        end
        @(posedge clk);
        #1;
        chk("init_done high", 32'(init_done), 32'd1);
        chk("idle mem_en", 32'(mem_en), 32'd0);

        for (int v = 0; v < 13; v++) begin
            req_valid = tv[v].valid;
            req_addr  = tv[v].addr;
            req_data  = tv[v].data;
            #1;
            chk($sformatf("v%0d ready", v), 32'(req_ready), 32'(tv[v].ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d mem_en", v), 32'(mem_en), 32'(tv[v].en));
            chk($sformatf("v%0d addr0", v), 32'(mem_addr[0]), 32'(tv[v].a0));
            chk($sformatf("v%0d addr1", v), 32'(mem_addr[1]), 32'(tv[v].a1));
            chk($sformatf("v%0d d0", v), 32'(mem_d[0]), 32'(tv[v].d0));
            chk($sformatf("v%0d d1", v), 32'(mem_d[1]), 32'(tv[v].d1));
        end

`ifdef LVT_WRITE_ARBITER_STATS_EN
        chk("grant_cnt", grant_cnt, 32'd18);
        chk("conflict_cnt", conflict_cnt, 32'd4);
`endif

        // Mid-RUN reset while both ports are writing
        req_valid = 4'b0011;
        req_addr  = {3'd0, 3'd0, 3'd2, 3'd1};
        req_data  = {8'h00, 8'h00, 8'h77, 8'h66};
        @(posedge clk);
        #1;
        chk("pre-reset mem_en", 32'(mem_en), 32'd3);
        rst = 1'b1;
        #1;
        chk("async rst mem_en", 32'(mem_en), 32'd0);
        chk("async rst mem_addr", 32'(mem_addr), 32'd0);
        chk("async rst req_ready", 32'(req_ready), 32'd0);
        chk("async rst init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'b0000;
        @(posedge clk);
        #1;
        chk("restart mem_en", 32'(mem_en), 32'd3);
        chk("restart addr0", 32'(mem_addr[0]), 32'd0);
        chk("restart addr1", 32'(mem_addr[1]), 32'd1);
`ifdef LVT_WRITE_ARBITER_STATS_EN
        chk("rst grant_cnt", grant_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
